// File: rtl/uio_tx_pkg.sv
// Shared types and constants for the uio pad-bus transmit end.
package uio_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        STROBE,
        RELEASE,
        TURN
    } tx_state_t;

    localparam logic [7:0] OE_ALL  = 8'hFF;
    localparam logic [7:0] OE_NONE = 8'h00;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uio_pipe_tx.sv
// uio pad-bus transmitter: byte FIFO feeding a 4-phase strobe/ack handshake
// on the shared IO pins, with per-edge timeout and sticky error flags.
module uio_pipe_tx
    import uio_tx_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int SETUP_CYCLES = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_en,
    input  logic                       clr_err,
    input  logic                       pad_ack,
    output logic [7:0]                 pad_out,
    output logic [7:0]                 pad_oe,
    output logic                       pad_stb,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy,
    output logic [7:0]                 sent_cnt,
    output logic                       err_ovf,
    output logic                       err_timeout
);

    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int CMAX = (SETUP_CYCLES > TIMEOUT) ? SETUP_CYCLES : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    logic            w_ack;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_nxt;
    logic            r_full;
    logic            w_push;
    logic            w_ovf;

    tx_state_t       r_state;
    tx_state_t       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [7:0]      r_pad_out;
    logic [7:0]      w_pad_out_nxt;
    logic [7:0]      r_pad_oe;
    logic [7:0]      w_pad_oe_nxt;
    logic            r_stb;
    logic            w_stb_nxt;
    logic            w_pop;
    logic            w_sent_inc;
    logic            w_to_evt;
    logic            r_busy;
    logic [7:0]      r_sent;
    logic            r_err_ovf;
    logic            r_err_to;

    sync_2ff u_ack_sync (
        .clk (clk),
        .rst (rst),
        .i_d (pad_ack),
        .o_q (w_ack)
    );

    // Push qualification uses the registered full flag, so a pop in the same
    // cycle does not rescue a push into a full FIFO.
    assign w_push = wr_en && !r_full;
    assign w_ovf  = wr_en && r_full;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pad_out_nxt = r_pad_out;
        w_pad_oe_nxt  = r_pad_oe;
        w_stb_nxt     = r_stb;
        w_pop         = 1'b0;
        w_sent_inc    = 1'b0;
        w_to_evt      = 1'b0;
        case (r_state)
            IDLE: begin
                w_pad_oe_nxt = OE_NONE;
                w_stb_nxt    = 1'b0;
                if (r_level != '0) begin
                    w_pop         = 1'b1;
                    w_pad_out_nxt = r_mem[r_rptr];
                    w_pad_oe_nxt  = OE_ALL;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                if (r_cnt == CW'(SETUP_CYCLES - 1)) begin
                    w_stb_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = STROBE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            STROBE: begin
                if (w_ack) begin
                    w_stb_nxt   = 1'b0;
                    w_sent_inc  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_stb_nxt    = 1'b0;
                    w_pad_oe_nxt = OE_NONE;
                    w_to_evt     = 1'b1;
                    w_state_nxt  = TURN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!w_ack) begin
                    w_pad_oe_nxt = OE_NONE;
                    w_state_nxt  = TURN;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_stb_nxt    = 1'b0;
                    w_pad_oe_nxt = OE_NONE;
                    w_to_evt     = 1'b1;
                    w_state_nxt  = TURN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            TURN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_pad_oe_nxt = OE_NONE;
                w_stb_nxt    = 1'b0;
                w_state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pad_out <= '0;
            r_pad_oe  <= OE_NONE;
            r_stb     <= 1'b0;
            r_busy    <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_sent    <= '0;
            r_err_ovf <= 1'b0;
            r_err_to  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pad_out <= w_pad_out_nxt;
            r_pad_oe  <= w_pad_oe_nxt;
            r_stb     <= w_stb_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_level   <= w_level_nxt;
            r_full    <= (w_level_nxt == LW'(DEPTH));
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_sent_inc) begin
                r_sent <= r_sent + 8'd1;
            end
            // An error event in the same cycle as clr_err keeps the flag set.
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
            end else if (clr_err) begin
                r_err_ovf <= 1'b0;
            end
            if (w_to_evt) begin
                r_err_to <= 1'b1;
            end else if (clr_err) begin
                r_err_to <= 1'b0;
            end
        end
    end

    assign pad_out     = r_pad_out;
    assign pad_oe      = r_pad_oe;
    assign pad_stb     = r_stb;
    assign full        = r_full;
    assign level       = r_level;
    assign busy        = r_busy;
    assign sent_cnt    = r_sent;
    assign err_ovf     = r_err_ovf;
    assign err_timeout = r_err_to;

endmodule

// File: tb/tb_uio_pipe_tx.sv
// Scoreboard bench for uio_pipe_tx: directed transfers, overflow, timeouts,
// reset mid-handshake and 256-transfer wrap, with a behavioural receiver.
module tb_uio_pipe_tx;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       clr_err;
    logic       pad_ack;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic       pad_stb;
    logic       full;
    logic [2:0] level;
    logic       busy;
    logic [7:0] sent_cnt;
    logic       err_ovf;
    logic       err_timeout;

    int         n_vec  = 0;
    int         n_fail = 0;
    int         ack_mode = 0;  // 0: normal, 1: never ack, 2: ack and hold
    logic [7:0] sb [$];

    uio_pipe_tx #(
        .DEPTH        (4),
        .SETUP_CYCLES (1),
        .TIMEOUT      (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .clr_err     (clr_err),
        .pad_ack     (pad_ack),
        .pad_out     (pad_out),
        .pad_oe      (pad_oe),
        .pad_stb     (pad_stb),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .sent_cnt    (sent_cnt),
        .err_ovf     (err_ovf),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input logic v, input int max, output int n);
        n = 0;
        while (pad_stb !== v && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_stb_%0d: no change after %0d cycles", v, max);
        end
    endtask

    task automatic wait_oe(input logic [7:0] v, input int max, output int n);
        n = 0;
        while (pad_oe !== v && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_oe_%0h: no change after %0d cycles", v, max);
        end
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while ((busy !== 1'b0 || level !== 3'd0) && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", max);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic expect_accept);
        wr_data = d;
        wr_en   = 1'b1;
        if (expect_accept) sb.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Far-end receiver
    initial begin
        int dly;
        dly = 0;
        pad_ack = 1'b0;
        forever begin
            tick();
            if (rst) begin
                pad_ack = 1'b0;
                dly = 0;
            end else if (ack_mode == 1) begin
                pad_ack = 1'b0;
            end else if (ack_mode == 2) begin
                if (pad_stb) pad_ack = 1'b1;
            end else if (pad_stb && !pad_ack) begin
                dly++;
                if (dly == 3) begin pad_ack = 1'b1; dly = 0; end
            end else if (!pad_stb && pad_ack) begin
                dly++;
                if (dly == 2) begin pad_ack = 1'b0; dly = 0; end
            end else begin
                dly = 0;
            end
        end
    end

    // Monitor: each strobe rise presents one byte
    initial begin
        logic       prev;
        logic [7:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pad_stb === 1'b1 && prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sb_unexpected: strobe with data 0x%0h, expected none", pad_out);
                end else begin
                    exp = sb.pop_front();
                    chk("sb_data", pad_out, exp);
                    chk("sb_oe", pad_oe, 8'hFF);
                end
            end
            prev = pad_stb;
        end
    end

    initial begin
        int n;
        int bad;
        logic [2:0] exp_lvl [6];
        logic       exp_full [6];
        exp_lvl  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_pad_out", pad_out, 8'h00);
        chk("rst_pad_oe", pad_oe, 8'h00);
        chk("rst_stb", pad_stb, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sent", sent_cnt, 8'd0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_to", err_timeout, 1'b0);

        // Single byte with latency checks
        push(8'hA5, 1'b1);
        chk("t1_e0_level", level, 3'd1);
        chk("t1_e0_oe", pad_oe, 8'h00);
        tick();
        chk("t1_e1_oe", pad_oe, 8'hFF);
        chk("t1_e1_data", pad_out, 8'hA5);
        chk("t1_e1_stb", pad_stb, 1'b0);
        chk("t1_e1_level", level, 3'd0);
        tick();
        chk("t1_e2_stb", pad_stb, 1'b1);
        wait_stb(1'b0, 50, n);
        chk("t1_release_oe", pad_oe, 8'hFF);
        chk("t1_release_sent", sent_cnt, 8'd1);
        wait_oe(8'h00, 50, n);
        chk("t1_turn_busy", busy, 1'b1);
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_level", level, 3'd0);

        // Back-to-back with overflow
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 1), i < 5);
            chk("t2_level", level, exp_lvl[i]);
            chk("t2_full", full, exp_full[i]);
        end
        chk("t2_err_ovf", err_ovf, 1'b1);
        wait_idle(400);
        chk("t2_sent", sent_cnt, 8'd6);
        chk("t2_sb_empty", sb.size(), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t2_clr_ovf", err_ovf, 1'b0);

        // Timeout waiting for ack high
        ack_mode = 1;
        push(8'h3C, 1'b1);
        wait_stb(1'b1, 20, n);
        wait_stb(1'b0, TO + 20, n);
        chk("t3_to_cycles", n, TO);
        chk("t3_oe", pad_oe, 8'h00);
        chk("t3_err_to", err_timeout, 1'b1);
        chk("t3_sent", sent_cnt, 8'd6);
        chk("t3_turn_busy", busy, 1'b1);
        tick();
        chk("t3_idle", busy, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_clr_to", err_timeout, 1'b0);

        // Timeout waiting for ack low
        ack_mode = 2;
        push(8'h77, 1'b1);
        wait_stb(1'b1, 20, n);
        wait_stb(1'b0, 40, n);
        chk("t4_sent", sent_cnt, 8'd7);
        chk("t4_release_oe", pad_oe, 8'hFF);
        wait_oe(8'h00, TO + 20, n);
        chk("t4_to_cycles", n, TO);
        chk("t4_err_to", err_timeout, 1'b1);
        chk("t4_sent_hold", sent_cnt, 8'd7);
        ack_mode = 0;
        repeat (8) tick();
        chk("t4_idle", busy, 1'b0);

        // Reset during an active strobe with two bytes queued
        ack_mode = 1;
        push(8'hAA, 1'b1);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b0);
        chk("t5_pre_stb", pad_stb, 1'b1);
        chk("t5_pre_level", level, 3'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ack_mode = 0;
        chk("t5_oe", pad_oe, 8'h00);
        chk("t5_stb", pad_stb, 1'b0);
        chk("t5_level", level, 3'd0);
        chk("t5_sent", sent_cnt, 8'd0);
        chk("t5_busy", busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pad_oe !== 8'h00 || pad_stb !== 1'b0) bad++;
        end
        chk("t5_quiet_pads", bad, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // 256 transfers: counter wraps, FIFO pointers wrap many times
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (full === 1'b1 && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) begin
                n_vec++;
                n_fail++;
                $display("FAIL t6_full_stuck: full held for %0d cycles", n);
            end
            push(8'(i), 1'b1);
        end
        wait_idle(6000);
        chk("t6_sent_wrap", sent_cnt, 8'd0);
        chk("t6_sb_empty", sb.size(), 0);
        chk("t6_err_ovf", err_ovf, 1'b0);
        chk("t6_err_to", err_timeout, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
